// File: rtl/i2d_core_defines.sv
// Shared types for the core bus arbiter: FSM states, master select and counter sizing.
package core_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } mst_sel_t;

    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/core_bus_arb_cnt.sv
// Saturating outstanding-request counter for the shared memory port.
// Increments on accept, decrements on ack, holds on both or neither; never wraps.
module core_bus_arb_cnt
    import core_bus_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CW      = cnt_width(MAX_OUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          inc_ok;
    logic          dec_ok;

    assign full_o = (cnt_q == CW'(MAX_OUT));
    assign zero_o = (cnt_q == '0);
    // Stray acks at zero and accepts at the ceiling are dropped here.
    assign inc_ok = inc_i && !full_o;
    assign dec_ok = dec_i && !zero_o;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_bus_arb.sv
// Two-master (instruction fetch / data) Wishbone pipelined arbiter onto one memory port.
// Grant is held until the owner drops cyc and all its outstanding requests are acked.
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic            i_we,
    input  logic [AW-1:0]   i_adr,
    input  logic [DW-1:0]   i_dat_w,
    input  logic [DW/8-1:0] i_sel,
    output logic            i_ack,
    output logic            i_stall,
    output logic [DW-1:0]   i_dat_r,
    input  logic            d_cyc,
    input  logic            d_stb,
    input  logic            d_we,
    input  logic [AW-1:0]   d_adr,
    input  logic [DW-1:0]   d_dat_w,
    input  logic [DW/8-1:0] d_sel,
    output logic            d_ack,
    output logic            d_stall,
    output logic [DW-1:0]   d_dat_r,
    output logic            m_cyc,
    output logic            m_stb,
    output logic            m_we,
    output logic [AW-1:0]   m_adr,
    output logic [DW-1:0]   m_dat_w,
    output logic [DW/8-1:0] m_sel,
    input  logic            m_ack,
    input  logic            m_stall,
    input  logic [DW-1:0]   m_dat_r
);

    arb_state_t state_q, state_d;
    mst_sel_t   last_gnt_q, last_gnt_d;
    logic       cnt_zero;
    logic       cnt_full;
    logic       accept;

    assign accept = m_stb && !m_stall;

    core_bus_arb_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (accept),
        .dec_i  (m_ack && (state_q != IDLE)),
        .zero_o (cnt_zero),
        .full_o (cnt_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= MST_I;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (i_cyc && d_cyc) begin
                    state_d = (last_gnt_q == MST_I) ? GNT_D : GNT_I;
                end else if (i_cyc) begin
                    state_d = GNT_I;
                end else if (d_cyc) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                if (!i_cyc && cnt_zero && !accept) begin
                    state_d    = IDLE;
                    last_gnt_d = MST_I;
                end
            end
            GNT_D: begin
                if (!d_cyc && cnt_zero && !accept) begin
                    state_d    = IDLE;
                    last_gnt_d = MST_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is broadcast; only the owner ever sees an ack qualifying it.
    assign i_dat_r = m_dat_r;
    assign d_dat_r = m_dat_r;

    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_dat_w = '0;
        m_sel   = '0;
        i_stall = 1'b1;
        d_stall = 1'b1;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        case (state_q)
            GNT_I: begin
                m_cyc   = i_cyc || !cnt_zero;
                m_stb   = i_stb && i_cyc && !cnt_full;
                m_we    = i_we;
                m_adr   = i_adr;
                m_dat_w = i_dat_w;
                m_sel   = i_sel;
                i_stall = m_stall || cnt_full;
                i_ack   = m_ack;
            end
            GNT_D: begin
                m_cyc   = d_cyc || !cnt_zero;
                m_stb   = d_stb && d_cyc && !cnt_full;
                m_we    = d_we;
                m_adr   = d_adr;
                m_dat_w = d_dat_w;
                m_sel   = d_sel;
                d_stall = m_stall || cnt_full;
                d_ack   = m_ack;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_bus_arb.sv
// Randomized bench for core_bus_arb: two bursting masters, a latency-randomized memory,
// and a cycle-level owner/outstanding reference model derived from the arbitration rules.
module tb_core_bus_arb;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_OUT = 4;
    localparam logic [DW-1:0] DMASK = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            cyc_r[2], stb_r[2], we_r[2];
    logic [AW-1:0]   adr_r[2];
    logic [DW-1:0]   dw_r[2];
    logic [DW/8-1:0] sel_r[2];
    logic            i_ack, i_stall, d_ack, d_stall;
    logic [DW-1:0]   i_dat_r, d_dat_r;
    logic            m_cyc, m_stb, m_we, m_ack, m_stall;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_dat_w, m_dat_r;
    logic [DW/8-1:0] m_sel;

    core_bus_arb #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(cyc_r[0]), .i_stb(stb_r[0]), .i_we(we_r[0]), .i_adr(adr_r[0]),
        .i_dat_w(dw_r[0]), .i_sel(sel_r[0]), .i_ack(i_ack), .i_stall(i_stall), .i_dat_r(i_dat_r),
        .d_cyc(cyc_r[1]), .d_stb(stb_r[1]), .d_we(we_r[1]), .d_adr(adr_r[1]),
        .d_dat_w(dw_r[1]), .d_sel(sel_r[1]), .d_ack(d_ack), .d_stall(d_stall), .d_dat_r(d_dat_r),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
        .m_sel(m_sel), .m_ack(m_ack), .m_stall(m_stall), .m_dat_r(m_dat_r)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Master drivers
    bit            act[2], start[2], early[2], early_k[2], held[2];
    int            rem[2], nstb[2], pend[2], accepts[2], real_acks[2];
    logic [AW-1:0] nadr[2], last_acc[2];
    int            first_who;

    // Memory model
    typedef struct {
        logic [AW-1:0] adr;
        int            who;
        int            due;
    } req_t;
    req_t mq[$];
    bit   hold, spur_now;
    int   stall_pct, spur_pct, lat_lo, lat_hi, stb_pct, cyc_n;

    // Reference model: owner 0=none 1=I 2=D, last winner, outstanding count
    int own, last, outst, own_n, last_n, outst_n;

    task automatic set_knobs(input int st, input int sp, input int llo, input int lhi, input int sb);
        stall_pct = st; spur_pct = sp; lat_lo = llo; lat_hi = lhi; stb_pct = sb;
    endtask

    task automatic start_m(input int m, input int n, input logic [AW-1:0] a, input bit e);
        start[m] = 1'b1; nstb[m] = n; nadr[m] = a; early_k[m] = e;
    endtask

    task automatic drive_masters();
        for (int m = 0; m < 2; m++) begin
            if (!act[m] && start[m]) begin
                act[m] = 1'b1; start[m] = 1'b0; rem[m] = nstb[m]; early[m] = early_k[m];
            end
            if (!act[m]) begin
                cyc_r[m] = 1'b0; stb_r[m] = 1'b0;
            end else begin
                cyc_r[m] = 1'b1;
                if (!(stb_r[m] && held[m])) begin
                    if (rem[m] > 0 && $urandom_range(99) < stb_pct) begin
                        stb_r[m] = 1'b1; adr_r[m] = nadr[m]; we_r[m] = 1'($urandom);
                        dw_r[m] = $urandom; sel_r[m] = (DW/8)'($urandom);
                    end else begin
                        stb_r[m] = 1'b0;
                    end
                end
                if (rem[m] == 0 && (pend[m] == 0 || early[m])) begin
                    act[m] = 1'b0; cyc_r[m] = 1'b0; stb_r[m] = 1'b0;
                end
            end
        end
    endtask

    task automatic drive_mem();
        spur_now = 1'b0; m_ack = 1'b0; m_dat_r = '0;
        m_stall = ($urandom_range(99) < stall_pct);
        if (mq.size() > 0) begin
            if (!hold && mq[0].due <= cyc_n) begin
                m_ack = 1'b1; m_dat_r = mq[0].adr ^ DMASK;
            end
        end else if ($urandom_range(99) < spur_pct) begin
            m_ack = 1'b1; spur_now = 1'b1; m_dat_r = $urandom;
        end
    endtask

    task automatic sample_check();
        int   x;
        logic e_cyc, e_stb, e_ist, e_dst, e_iack, e_dack, acc, ackv;
        logic [1:0] st_o, ack_o;
        req_t r;
        x = 0;
        e_cyc = 1'b0; e_stb = 1'b0; e_ist = 1'b1; e_dst = 1'b1; e_iack = 1'b0; e_dack = 1'b0;
        if (own != 0) begin
            x = own - 1;
            e_cyc = cyc_r[x] || (outst > 0);
            e_stb = stb_r[x] && cyc_r[x] && (outst < MAX_OUT);
            if (x == 0) begin
                e_ist = m_stall || (outst == MAX_OUT); e_iack = m_ack;
            end else begin
                e_dst = m_stall || (outst == MAX_OUT); e_dack = m_ack;
            end
        end
        chk("m_cyc", m_cyc, e_cyc);
        chk("m_stb", m_stb, e_stb);
        chk("i_stall", i_stall, e_ist);
        chk("d_stall", d_stall, e_dst);
        chk("i_ack", i_ack, e_iack);
        chk("d_ack", d_ack, e_dack);
        if (own != 0) begin
            chk("m_adr", m_adr, adr_r[x]);
            chk("m_we", m_we, we_r[x]);
            chk("m_dat_w", m_dat_w, dw_r[x]);
            chk("m_sel", m_sel, sel_r[x]);
            if (m_ack && !spur_now && mq.size() > 0) begin
                chk("ack_owner", 64'(x), 64'(mq[0].who));
                chk("dat_r", (x == 0) ? i_dat_r : d_dat_r, mq[0].adr ^ DMASK);
            end
        end
        acc  = e_stb && !m_stall;
        ackv = (own != 0) && m_ack && (outst > 0);
        outst_n = outst + (acc ? 1 : 0) - (ackv ? 1 : 0);
        own_n = own; last_n = last;
        if (own == 0) begin
            if (cyc_r[0] && cyc_r[1]) own_n = (last == 1) ? 2 : 1;
            else if (cyc_r[0]) own_n = 1;
            else if (cyc_r[1]) own_n = 2;
        end else if (!cyc_r[own-1] && outst == 0) begin
            own_n = 0; last_n = own;
        end
        st_o  = {d_stall, i_stall};
        ack_o = {d_ack, i_ack};
        for (int m = 0; m < 2; m++) begin
            held[m] = stb_r[m] && st_o[m];
            if (cyc_r[m] && stb_r[m] && !st_o[m]) begin
                if (rem[m] > 0) rem[m]--;
                r.adr = adr_r[m]; r.who = m; r.due = cyc_n + $urandom_range(lat_hi, lat_lo);
                mq.push_back(r);
                pend[m]++; accepts[m]++; last_acc[m] = adr_r[m]; nadr[m] += 4;
                if (first_who < 0) first_who = m;
            end
            if (ack_o[m]) begin
                if (pend[m] > 0) pend[m]--;
                if (!spur_now) real_acks[m]++;
            end
        end
        if (m_ack && !spur_now && mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic step();
        drive_masters();
        drive_mem();
        #4;
        sample_check();
        @(posedge clk);
        own = own_n; last = last_n; outst = outst_n; cyc_n++;
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        #4;
        if (check) begin
            chk("rst_m_cyc", m_cyc, 1'b0);
            chk("rst_m_stb", m_stb, 1'b0);
            chk("rst_i_stall", i_stall, 1'b1);
            chk("rst_d_stall", d_stall, 1'b1);
            chk("rst_i_ack", i_ack, 1'b0);
            chk("rst_d_ack", d_ack, 1'b0);
        end
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            cyc_r[m] = 1'b0; stb_r[m] = 1'b0; we_r[m] = 1'b0; adr_r[m] = '0; dw_r[m] = '0;
            sel_r[m] = '0; act[m] = 1'b0; start[m] = 1'b0; held[m] = 1'b0; rem[m] = 0;
            pend[m] = 0; accepts[m] = 0; real_acks[m] = 0; last_acc[m] = '0;
        end
        mq.delete();
        m_ack = 1'b0; m_stall = 1'b0; m_dat_r = '0; hold = 1'b0;
        own = 0; last = 1; outst = 0; first_who = -1; cyc_n = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        set_knobs(0, 0, 2, 2, 100);
        do_reset(1'b0);

        // Single I burst, acks two cycles after each accept
        start_m(0, 3, 32'h100, 1'b0);
        run(12);
        chk("burst_i_acks", 64'(real_acks[0]), 3);
        chk("burst_d_acks", 64'(real_acks[1]), 0);
        chk("burst_last_adr", last_acc[0], 32'h108);

        // Tie after reset goes to D, then I after one idle bubble
        do_reset(1'b1);
        start_m(0, 2, 32'h200, 1'b0);
        start_m(1, 2, 32'h300, 1'b0);
        run(16);
        chk("tie_first", 64'(first_who), 1);
        chk("tie_i_acks", 64'(real_acks[0]), 2);
        chk("tie_d_acks", 64'(real_acks[1]), 2);

        // Saturation at MAX_OUT with acks withheld, then release
        do_reset(1'b1);
        hold = 1'b1;
        start_m(0, 6, 32'h1000, 1'b0);
        run(8);
        chk("sat_accepts", 64'(accepts[0]), MAX_OUT);
        hold = 1'b0;
        run(20);
        chk("sat_acks", 64'(real_acks[0]), 6);

        // Early cyc drop by D with two outstanding, I waiting
        do_reset(1'b1);
        set_knobs(0, 0, 3, 3, 100);
        start_m(1, 2, 32'h400, 1'b1);
        run(2);
        start_m(0, 1, 32'h500, 1'b0);
        run(18);
        chk("drop_d_acks", 64'(real_acks[1]), 2);
        chk("drop_i_acks", 64'(real_acks[0]), 1);

        // Reset mid-burst with two outstanding, then a clean transfer
        do_reset(1'b1);
        hold = 1'b1;
        start_m(0, 4, 32'h800, 1'b0);
        run(3);
        chk("midrst_accepts", 64'(accepts[0]), 2);
        do_reset(1'b1);
        start_m(0, 1, 32'h900, 1'b0);
        run(8);
        chk("post_rst_acks", 64'(real_acks[0]), 1);

        // Randomized traffic
        do_reset(1'b1);
        set_knobs(25, 10, 1, 4, 70);
        for (int c = 0; c < 4000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && !start[m] && pend[m] == 0 && $urandom_range(3) == 0)
                    start_m(m, $urandom_range(7, 1), {$urandom} & 32'hFFFF_FFFC, $urandom_range(3) == 0);
            end
            if ($urandom_range(999) == 0) do_reset(1'b1);
            else step();
        end
        run(100);
        chk("drain_i", 64'(real_acks[0]), 64'(accepts[0]));
        chk("drain_d", 64'(real_acks[1]), 64'(accepts[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
